// File: rtl/imem_access_arbiter.sv
// Shares the single-port IMEM SRAM between core fetch (priority) and a preload write stream.
// Grants are combinational; fetch data returns 1 cycle after grant; preload is force-granted after MAX_WAIT denials.
module imem_access_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pl_valid,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_wdata,
  output logic              pl_ready,
  input  logic              pl_lock,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              locked,
  output logic [15:0]       pl_wr_count
);

  typedef enum logic [1:0] {
    CORE_PRI = 2'd0,
    PL_BOOST = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        core_rvalid_q, core_rvalid_d;
  logic [15:0] pl_wr_count_q, pl_wr_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CORE_PRI;
      wait_cnt_q    <= '0;
      core_rvalid_q <= 1'b0;
      pl_wr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      core_rvalid_q <= core_rvalid_d;
      pl_wr_count_q <= pl_wr_count_d;
    end
  end

  // Grants are forced low during reset so nothing reaches the SRAM.
  always_comb begin
    core_gnt = 1'b0;
    pl_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        LOCKED: pl_ready = pl_valid;
        PL_BOOST: begin
          if (pl_valid) pl_ready = 1'b1;
          else          core_gnt = core_req;
        end
        default: begin
          if (core_req) core_gnt = 1'b1;
          else          pl_ready = pl_valid;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (pl_lock) begin
      state_d    = LOCKED;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        LOCKED, PL_BOOST: begin
          state_d    = CORE_PRI;
          wait_cnt_d = '0;
        end
        default: begin
          if (!pl_valid || pl_ready) begin
            wait_cnt_d = '0;
          end else begin
            if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
            // Boost the cycle after the denial count reaches the limit.
            if (wait_cnt_q + 4'd1 >= MAX_WAIT_C) state_d = PL_BOOST;
          end
        end
      endcase
    end
  end

  always_comb begin
    core_rvalid_d = core_gnt;
    pl_wr_count_d = pl_wr_count_q;
    if (pl_ready && (pl_wr_count_q != 16'hFFFF)) pl_wr_count_d = pl_wr_count_q + 16'd1;
  end

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (pl_ready) begin
      sram_cs    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = pl_addr;
      sram_wdata = pl_wdata;
    end else if (core_gnt) begin
      sram_cs   = 1'b1;
      sram_addr = core_addr;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rvalid_q ? sram_rdata : '0;
  assign locked      = (state_q == LOCKED);
  assign pl_wr_count = pl_wr_count_q;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Randomized and directed bench for imem_access_arbiter against a cycle-level behavioural model.
module tb_imem_access_arbiter;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pl_valid, pl_ready, pl_lock;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_wdata;
  logic          core_req, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_rdata;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          locked;
  logic [15:0]   pl_wr_count;

  imem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .pl_valid(pl_valid), .pl_addr(pl_addr), .pl_wdata(pl_wdata), .pl_ready(pl_ready),
    .pl_lock(pl_lock),
    .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .locked(locked), .pl_wr_count(pl_wr_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural SRAM seen by the DUT, and the reference contents the model expects.
  logic [DW-1:0] tb_mem  [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) tb_mem[sram_addr] <= sram_wdata;
      else         sram_rdata        <= tb_mem[sram_addr];
    end
  end

  // Model state: lock window, one-cycle boost, consecutive preload denials.
  bit            m_locked, m_boost, m_rvalid;
  int            m_wait, m_count;
  logic [DW-1:0] m_rdata;
  bit            last_gnt, last_rdy;

  task automatic model_reset();
    m_locked = 0; m_boost = 0; m_rvalid = 0; m_wait = 0; m_count = 0;
    m_rdata = '0; last_gnt = 0; last_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_req = 0; pl_valid = 0; pl_lock = 0;
    core_addr = '0; pl_addr = '0; pl_wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Predicts and checks one clock cycle with the inputs currently driven, then advances.
  task automatic model_cycle(input string tag);
    bit eg, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, erd;
    @(negedge clk);
    eg = 0; er = 0;
    if (m_locked)                er = pl_valid;
    else if (m_boost && pl_valid) er = 1;
    else if (core_req)           eg = 1;
    else                         er = pl_valid;
    ea  = er ? pl_addr : (eg ? core_addr : '0);
    ed  = er ? pl_wdata : '0;
    erd = m_rvalid ? m_rdata : '0;

    n_total++; if (core_gnt !== eg) $display("FAIL %s core_gnt got %b exp %b", tag, core_gnt, eg); else n_pass++;
    n_total++; if (pl_ready !== er) $display("FAIL %s pl_ready got %b exp %b", tag, pl_ready, er); else n_pass++;
    n_total++; if (sram_cs !== (eg | er)) $display("FAIL %s sram_cs got %b exp %b", tag, sram_cs, eg | er); else n_pass++;
    n_total++; if (sram_we !== er) $display("FAIL %s sram_we got %b exp %b", tag, sram_we, er); else n_pass++;
    n_total++; if (sram_addr !== ea) $display("FAIL %s sram_addr got %h exp %h", tag, sram_addr, ea); else n_pass++;
    n_total++; if (sram_wdata !== ed) $display("FAIL %s sram_wdata got %h exp %h", tag, sram_wdata, ed); else n_pass++;
    n_total++; if (locked !== m_locked) $display("FAIL %s locked got %b exp %b", tag, locked, m_locked); else n_pass++;
    n_total++; if (core_rvalid !== m_rvalid) $display("FAIL %s core_rvalid got %b exp %b", tag, core_rvalid, m_rvalid); else n_pass++;
    n_total++; if (core_rdata !== erd) $display("FAIL %s core_rdata got %h exp %h", tag, core_rdata, erd); else n_pass++;
    n_total++; if (pl_wr_count !== 16'(m_count)) $display("FAIL %s pl_wr_count got %0d exp %0d", tag, pl_wr_count, m_count); else n_pass++;

    m_rvalid = eg;
    if (eg) m_rdata = ref_mem[core_addr];
    if (er) begin
      ref_mem[pl_addr] = pl_wdata;
      if (m_count < 65535) m_count++;
    end
    if (pl_lock) begin
      m_locked = 1; m_boost = 0; m_wait = 0;
    end else if (m_locked || m_boost) begin
      m_locked = 0; m_boost = 0; m_wait = 0;
    end else if (pl_valid && !er) begin
      m_wait++;
      if (m_wait >= MW) m_boost = 1;
    end else begin
      m_wait = 0;
    end
    last_gnt = eg;
    last_rdy = er;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; core_req = 1; pl_valid = 1; pl_lock = 0;
    core_addr = 13'h010; pl_addr = 13'h020; pl_wdata = 64'h1;
    @(negedge clk);
    n_total++; if (core_gnt !== 1'b0) $display("FAIL reset core_gnt got %b exp 0", core_gnt); else n_pass++;
    n_total++; if (pl_ready !== 1'b0) $display("FAIL reset pl_ready got %b exp 0", pl_ready); else n_pass++;
    n_total++; if (sram_cs !== 1'b0) $display("FAIL reset sram_cs got %b exp 0", sram_cs); else n_pass++;
    n_total++; if (core_rvalid !== 1'b0) $display("FAIL reset core_rvalid got %b exp 0", core_rvalid); else n_pass++;
    n_total++; if (pl_wr_count !== 16'd0) $display("FAIL reset pl_wr_count got %0d exp 0", pl_wr_count); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL reset locked got %b exp 0", locked); else n_pass++;
    do_reset();
    model_cycle("idle");
  endtask

  task automatic test_single_fetch();
    do_reset();
    core_req = 1; core_addr = 13'h010;
    model_cycle("fetch_gnt");
    core_req = 0;
    model_cycle("fetch_rvalid");
  endtask

  task automatic test_boost();
    int denied = 0;
    bit got = 0;
    do_reset();
    core_req = 1; core_addr = 13'h001;
    pl_valid = 1; pl_addr = 13'h020; pl_wdata = 64'hA5A5_0000_0000_5A5A;
    for (int i = 0; i < 20 && !got; i++) begin
      model_cycle("boost");
      if (last_rdy) got = 1;
      else begin
        denied++;
        if (last_gnt) core_addr = AW'($urandom_range(0, 15));
      end
    end
    n_total++; if (!got || denied != 4) $display("FAIL boost_denials got %0d exp 4", denied); else n_pass++;
    n_total++; if (pl_wr_count !== 16'd1) $display("FAIL boost_count got %0d exp 1", pl_wr_count); else n_pass++;
    pl_valid = 0;
    model_cycle("boost_resume");
    core_addr = 13'h020;
    model_cycle("boost_readback");
    n_total++; if (core_rdata !== 64'hA5A5_0000_0000_5A5A) $display("FAIL boost_rdata got %h exp a5a500000000 5a5a", core_rdata); else n_pass++;
    core_req = 0;
    model_cycle("boost_tail");
  endtask

  task automatic test_lock();
    do_reset();
    core_req = 1; core_addr = 13'h030; pl_lock = 1;
    model_cycle("lock_enter");
    pl_valid = 1;
    for (int i = 0; i < 256; i++) begin
      pl_addr = AW'(13'h100 + i);
      pl_wdata = {$urandom, $urandom};
      model_cycle("lock_stream");
    end
    n_total++; if (pl_wr_count !== 16'd256) $display("FAIL lock_count got %0d exp 256", pl_wr_count); else n_pass++;
    n_total++; if (locked !== 1'b1) $display("FAIL lock_locked got %b exp 1", locked); else n_pass++;
    pl_lock = 0; pl_valid = 0;
    model_cycle("lock_drop");
    model_cycle("lock_release_gnt");
    n_total++; if (core_rvalid !== 1'b1) $display("FAIL lock_release_rvalid got %b exp 1", core_rvalid); else n_pass++;
    core_req = 0;
  endtask

  task automatic test_lock_entry();
    do_reset();
    core_req = 1; core_addr = 13'h040; pl_lock = 1;
    model_cycle("lock_entry_gnt");
    n_total++; if (core_rvalid !== 1'b1 || locked !== 1'b1) $display("FAIL lock_entry rvalid/locked got %b%b exp 11", core_rvalid, locked); else n_pass++;
    core_addr = 13'h041;
    repeat (4) model_cycle("lock_entry_hold");
    pl_lock = 0;
    model_cycle("lock_entry_exit");
    model_cycle("lock_entry_regrant");
    core_req = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pl_valid = 1; pl_addr = 13'h050; pl_wdata = 64'hDEAD_BEEF_0123_4567;
    model_cycle("mid_write");
    pl_valid = 0; core_req = 1; core_addr = 13'h050;
    model_cycle("mid_gnt");
    n_total++; if (core_rvalid !== 1'b1) $display("FAIL mid_pre_rvalid got %b exp 1", core_rvalid); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (core_rvalid !== 1'b0) $display("FAIL mid_rvalid got %b exp 0", core_rvalid); else n_pass++;
    n_total++; if (pl_wr_count !== 16'd0) $display("FAIL mid_count got %0d exp 0", pl_wr_count); else n_pass++;
    n_total++; if (core_gnt !== 1'b0) $display("FAIL mid_gnt got %b exp 0", core_gnt); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    pl_valid = 1; pl_addr = 13'h051;
    model_cycle("mid_after");
    core_req = 0;
    model_cycle("mid_after2");
    pl_valid = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!(core_req && !last_gnt) || $urandom_range(0, 9) == 0) begin
        core_req  = ($urandom_range(0, 3) != 0);
        core_addr = AW'($urandom_range(0, 63));
      end
      if (!(pl_valid && !last_rdy) || $urandom_range(0, 9) == 0) begin
        pl_valid = ($urandom_range(0, 3) != 0);
        pl_addr  = AW'($urandom_range(0, 63));
        pl_wdata = {$urandom, $urandom};
      end
      if ($urandom_range(0, 24) == 0) pl_lock = ~pl_lock;
      model_cycle("random");
    end
    core_req = 0; pl_valid = 0; pl_lock = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    pl_valid = 1;
    for (int i = 0; i < 65540; i++) begin
      pl_addr  = AW'($urandom_range(0, 8191));
      pl_wdata = {$urandom, $urandom};
      model_cycle("saturate");
    end
    n_total++; if (pl_wr_count !== 16'hFFFF) $display("FAIL saturate_count got %h exp ffff", pl_wr_count); else n_pass++;
    pl_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      tb_mem[i]  = {32'hC0DE_0000 | 32'(i), ~32'(i)};
      ref_mem[i] = {32'hC0DE_0000 | 32'(i), ~32'(i)};
    end
    model_reset();
    test_reset();
    test_single_fetch();
    test_boost();
    test_lock();
    test_lock_entry();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
